// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// The segment table is active-low: bit 7 is dp, bits 6..0 are g..a.
package seg_pkg;

  localparam int          DP_BIT  = 7;
  localparam logic [3:0]  SEL_OFF = 4'hF;
  localparam logic [7:0]  SEG_OFF = 8'hFF;

  localparam logic [7:0] SEG_TABLE [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // One displayed value: two decimal digits plus the "hundreds dropped" flag.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       dp;
  } pair_t;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit, input logic dp);
    logic [7:0] code;
    if (digit < 4'd10) begin
      code = SEG_TABLE[digit];
    end else begin
      code = SEG_OFF;
    end
    code[DP_BIT] = code[DP_BIT] & ~dp;
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Serial double-dabble converter: 8-bit binary to 3-digit BCD.
// One shift per cycle; done is asserted for one cycle while the result is valid.
module bin2bcd8
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e state_q, state_d;
  logic [2:0]  cnt_q;
  logic [19:0] sr_q;
  logic [19:0] adj_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == 3'd7) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    done = (state_q == DONE);
    bcd  = sr_q[19:8];
  end

  // Add-3 correction on every BCD nibble that is 5 or more before the shift
  always_comb begin
    adj_s = sr_q;
    if (sr_q[11:8] >= 4'd5) adj_s[11:8] = sr_q[11:8] + 4'd3;
    else adj_s[11:8] = sr_q[11:8];
    if (sr_q[15:12] >= 4'd5) adj_s[15:12] = sr_q[15:12] + 4'd3;
    else adj_s[15:12] = sr_q[15:12];
    if (sr_q[19:16] >= 4'd5) adj_s[19:16] = sr_q[19:16] + 4'd3;
    else adj_s[19:16] = sr_q[19:16];
  end

  // Shift register and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= 20'd0;
      cnt_q <= 3'd0;
    end else if ((state_q == IDLE) && start) begin
      sr_q  <= {12'd0, bin};
      cnt_q <= 3'd0;
    end else if (state_q == SHIFT) begin
      sr_q  <= {adj_s[18:0], 1'b0};
      cnt_q <= cnt_q + 3'd1;
    end else begin
      sr_q  <= sr_q;
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scan driver for two 8-bit values.
// New digits are committed only at frame start, so a frame never mixes old and new values.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dat1,
  input  logic [7:0] dat2,
  output logic [7:0] seg_out,
  output logic [3:0] sel
);

  localparam int DW = $clog2(DIV);

  logic [DW-1:0] div_q;
  logic [1:0]    dig_q;
  pair_t         pend1_q, pend2_q, disp1_q, disp2_q;
  pair_t         src1_s, src2_s;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    digit_s;
  logic          dp_s;
  logic          frame_start_s, div_wrap_s;
  logic          done1_s, done2_s;
  logic [11:0]   bcd1_s, bcd2_s;

  assign frame_start_s = (dig_q == 2'd3) && (div_q == '0);
  assign div_wrap_s    = (div_q == DW'(DIV - 1));

  bin2bcd8 u_conv1 (
    .clk  (clk),
    .rst  (rst),
    .start(frame_start_s),
    .bin  (dat1),
    .done (done1_s),
    .bcd  (bcd1_s)
  );

  bin2bcd8 u_conv2 (
    .clk  (clk),
    .rst  (rst),
    .start(frame_start_s),
    .bin  (dat2),
    .done (done2_s),
    .bcd  (bcd2_s)
  );

  // Digit mux; at frame start the pending pair bypasses so seg and sel switch together
  always_comb begin
    src1_s = frame_start_s ? pend1_q : disp1_q;
    src2_s = frame_start_s ? pend2_q : disp2_q;
    case (dig_q)
      2'd3:    begin digit_s = src1_s.tens; dp_s = 1'b0;      end
      2'd2:    begin digit_s = src1_s.ones; dp_s = src1_s.dp; end
      2'd1:    begin digit_s = src2_s.tens; dp_s = 1'b0;      end
      2'd0:    begin digit_s = src2_s.ones; dp_s = src2_s.dp; end
      default: begin digit_s = 4'd0;        dp_s = 1'b0;      end
    endcase
    seg_d = seg_encode(digit_s, dp_s);
    sel_d = ~(4'b0001 << dig_q);
  end

  // Scan counters, display/pending registers and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      dig_q   <= 2'd3;
      pend1_q <= '0;
      pend2_q <= '0;
      disp1_q <= '0;
      disp2_q <= '0;
      seg_q   <= SEG_OFF;
      sel_q   <= SEL_OFF;
    end else begin
      seg_q <= seg_d;
      sel_q <= sel_d;
      if (div_wrap_s) begin
        div_q <= '0;
        dig_q <= dig_q - 2'd1;
      end else begin
        div_q <= div_q + DW'(1);
        dig_q <= dig_q;
      end
      if (frame_start_s) begin
        disp1_q <= pend1_q;
        disp2_q <= pend2_q;
      end else begin
        disp1_q <= disp1_q;
        disp2_q <= disp2_q;
      end
      if (done1_s && done2_s) begin
        pend1_q <= '{tens: bcd1_s[7:4], ones: bcd1_s[3:0], dp: |bcd1_s[11:8]};
        pend2_q <= '{tens: bcd2_s[7:4], ones: bcd2_s[3:0], dp: |bcd2_s[11:8]};
      end else begin
        pend1_q <= pend1_q;
        pend2_q <= pend2_q;
      end
    end
  end

  assign seg_out = seg_q;
  assign sel     = sel_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with DIV = 16: scan order, BCD display, dp, frame-atomic commit, reset.
module tb_seg_scan;

  localparam int DIV   = 16;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dat1, dat2;
  logic [7:0] seg_out;
  logic [3:0] sel;

  int checks   = 0;
  int failures = 0;

  logic [7:0] obs_seg [FRAME];
  logic [3:0] obs_sel [FRAME];
  logic [3:0] sel_exp [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  seg_scan #(.DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .dat1   (dat1),
    .dat2   (dat2),
    .seg_out(seg_out),
    .sel    (sel)
  );

  always #5 clk = ~clk;

  // Record outputs at the negedge after each of the next n rising edges
  task automatic capture(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      obs_seg[i] = seg_out;
      obs_sel[i] = sel;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dat1 = 8'd12; dat2 = 8'd34;
    repeat (3) @(negedge clk);
    checks++;
    if (seg_out !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h want=ff", seg_out); end
    checks++;
    if (sel !== 4'hF) begin failures++; $display("FAIL reset_sel got=%b want=1111", sel); end
    rst = 1'b0;
    capture(0, FRAME);
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs_sel[i] !== sel_exp[i/DIV] || obs_seg[i] !== 8'hC0) begin
        failures++;
        $display("FAIL scan_frame0 cyc=%0d got sel=%b seg=%h want sel=%b seg=c0",
                 i, obs_sel[i], obs_seg[i], sel_exp[i/DIV]);
      end
    end
  endtask

  task automatic test_nominal();
    logic [7:0] e [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
    capture(0, FRAME);
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs_sel[i] !== sel_exp[i/DIV] || obs_seg[i] !== e[i/DIV]) begin
        failures++;
        $display("FAIL nominal cyc=%0d got sel=%b seg=%h want sel=%b seg=%h",
                 i, obs_sel[i], obs_seg[i], sel_exp[i/DIV], e[i/DIV]);
      end
    end
  endtask

  task automatic test_mid_frame();
    logic [7:0] e [3][4] = '{'{8'hF9, 8'hA4, 8'hB0, 8'h99},
                             '{8'hF9, 8'hA4, 8'hB0, 8'h99},
                             '{8'h92, 8'h82, 8'hF8, 8'h80}};
    for (int f = 0; f < 3; f++) begin
      if (f == 0) begin
        capture(0, 30);
        dat1 = 8'd56; dat2 = 8'd78;
        capture(30, FRAME - 30);
      end else begin
        capture(0, FRAME);
      end
      for (int i = 0; i < FRAME; i++) begin
        checks++;
        if (obs_sel[i] !== sel_exp[i/DIV] || obs_seg[i] !== e[f][i/DIV]) begin
          failures++;
          $display("FAIL mid_frame f=%0d cyc=%0d got sel=%b seg=%h want sel=%b seg=%h",
                   f, i, obs_sel[i], obs_seg[i], sel_exp[i/DIV], e[f][i/DIV]);
        end
      end
    end
  endtask

  task automatic test_hundreds();
    logic [7:0] e [2][4] = '{'{8'h92, 8'h82, 8'hF8, 8'h80},
                             '{8'hC0, 8'h12, 8'h92, 8'h12}};
    dat1 = 8'd105; dat2 = 8'd255;
    for (int f = 0; f < 2; f++) begin
      capture(0, FRAME);
      for (int i = 0; i < FRAME; i++) begin
        checks++;
        if (obs_seg[i] !== e[f][i/DIV]) begin
          failures++;
          $display("FAIL hundreds f=%0d cyc=%0d got seg=%h want seg=%h",
                   f, i, obs_seg[i], e[f][i/DIV]);
        end
      end
    end
  endtask

  task automatic test_counting();
    logic [7:0] e [3][4] = '{'{8'hC0, 8'h12, 8'h92, 8'h12},
                             '{8'h90, 8'h90, 8'hC0, 8'hC0},
                             '{8'hC0, 8'h40, 8'h92, 8'h12}};
    dat1 = 8'd99; dat2 = 8'd0;
    for (int f = 0; f < 3; f++) begin
      capture(0, FRAME);
      if (f == 0) begin
        dat1 = 8'd100; dat2 = 8'd255;
      end
      for (int i = 0; i < FRAME; i++) begin
        checks++;
        if (obs_seg[i] !== e[f][i/DIV]) begin
          failures++;
          $display("FAIL counting f=%0d cyc=%0d got seg=%h want seg=%h",
                   f, i, obs_seg[i], e[f][i/DIV]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e [2][4] = '{'{8'hC0, 8'hC0, 8'hC0, 8'hC0},
                             '{8'h99, 8'hA4, 8'hC0, 8'hF8}};
    dat1 = 8'd42; dat2 = 8'd7;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (seg_out !== 8'hFF || sel !== 4'hF) begin
      failures++;
      $display("FAIL reset_mid_async got seg=%h sel=%b want seg=ff sel=1111", seg_out, sel);
    end
    @(negedge clk);
    checks++;
    if (seg_out !== 8'hFF || sel !== 4'hF) begin
      failures++;
      $display("FAIL reset_mid_hold got seg=%h sel=%b want seg=ff sel=1111", seg_out, sel);
    end
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      capture(0, FRAME);
      for (int i = 0; i < FRAME; i++) begin
        checks++;
        if (obs_sel[i] !== sel_exp[i/DIV] || obs_seg[i] !== e[f][i/DIV]) begin
          failures++;
          $display("FAIL reset_mid f=%0d cyc=%0d got sel=%b seg=%h want sel=%b seg=%h",
                   f, i, obs_sel[i], obs_seg[i], sel_exp[i/DIV], e[f][i/DIV]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mid_frame();
    test_hundreds();
    test_counting();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
